ps2_host: RTL and testbench
===========================

# ps2_host

Host-side PS/2 controller: the core-side counterpart to an emulated PS/2 keyboard/mouse device. It receives device-to-host frames from an open-drain PS/2 clock/data pair and transmits host-to-device command bytes (LED updates, resets, mouse mode). Cores instantiate it between the PS/2 lines and their keyboard/mouse controller logic, all in the `clk_sys` domain.

## Interface
- `FILTER`, 8: `clk_sys` cycles an input level must hold before it is accepted (glitch filter).
- `INHIBIT_CYCLES`, 5000: host clock-low hold before a transmission (≥100 µs at `clk_sys`).
- `TIMEOUT_CYCLES`, 100000: maximum gap between PS/2 clock falling edges inside a frame.
- `clk_sys` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `ps2_clk_in` in 1: PS/2 clock line level (asynchronous).
- `ps2_dat_in` in 1: PS/2 data line level (asynchronous).
- `ps2_clk_out` out 1: 0 drives the clock line low; 1 releases it.
- `ps2_dat_out` out 1: 0 drives the data line low; 1 releases it.
- `tx_data` in 8: command byte, sampled on `tx_strobe`.
- `tx_strobe` in 1: one-cycle transmit request. Ignored while `tx_busy`=1.
- `tx_busy` out 1: a transmission is in progress.
- `tx_done` out 1: one-cycle pulse at the end of a transmission.
- `tx_error` out 1: valid with `tx_done`. 1 means no ACK or a timeout.
- `rx_data` out 8: last good received byte. Holds until the next good frame.
- `rx_strobe` out 1: one-cycle pulse when `rx_data` updates.
- `rx_error` out 1: one-cycle pulse on a bad start, parity, stop or timeout.

## Operation
- **Input conditioning.** Both inputs pass through a 2-FF synchronizer and then a filter. The filtered value takes the synced value once it has differed from the filtered value for `FILTER` consecutive cycles. A falling edge is `f_clk_prev & ~f_clk`. All protocol actions use the filtered clock and data.
- **States:** IDLE, RX, TX_INH, TX_REQ, TX_BITS, TX_ACK, TX_WAIT.
- **IDLE.** Both outputs are 1.
  - A falling edge with filtered data = 0 moves to RX, bit count 0.
  - A falling edge with data = 1 pulses `rx_error` and stays in IDLE.
- **RX.** Samples data on each subsequent falling edge: 8 data bits LSB first, then parity, then stop.
  - On the stop edge, the frame is good if odd parity holds (`^{data,parity}`=1) and stop = 1.
  - Good frame: load `rx_data`, pulse `rx_strobe`.
  - Bad frame: pulse `rx_error`; `rx_data` is unchanged.
  - Either way, return to IDLE.
- **Transmit accept.** `tx_strobe` with `tx_busy`=0, from any state:
  - latches `tx_data` and computes parity as `~^tx_data`;
  - sets `tx_busy`;
  - silently aborts any RX frame in progress (no strobe, no error);
  - enters TX_INH.
- **TX_INH.** `ps2_clk_out`=0 for `INHIBIT_CYCLES` cycles. Then `ps2_dat_out`=0 (start bit) and `ps2_clk_out`=1, entering TX_REQ/TX_BITS.
- **TX_BITS.** On each device falling edge, in order:
  - edges 1–8: `ps2_dat_out` ← d0..d7;
  - edge 9: `ps2_dat_out` ← parity;
  - edge 10: `ps2_dat_out` ← 1 (stop, released);
  - then go to TX_ACK.
- **TX_ACK.** On the next falling edge, sample data: 0 = ACK, 1 = NACK. Go to TX_WAIT.
- **TX_WAIT.** When filtered clock and data are both 1:
  - pulse `tx_done`, with `tx_error` = NACK;
  - clear `tx_busy`;
  - return to IDLE.
- **Timeout.** In RX, TX_BITS, TX_ACK or TX_WAIT, a counter reloads on every falling edge and on state entry. Reaching `TIMEOUT_CYCLES` triggers an abort:
  - both outputs return to 1;
  - from RX: pulse `rx_error`;
  - from TX: pulse `tx_done` with `tx_error`=1 and clear `tx_busy`;
  - go to IDLE.
- **Reset values.** `ps2_clk_out`=1, `ps2_dat_out`=1, `rx_data`=0, and all strobes, errors and `tx_busy` = 0. State = IDLE; synchronizers and filter at 1.
- **Reset mid-frame.** Abandons the frame within one cycle and releases both lines. No pulses are generated.

## Timing
- Pin-to-filtered latency is 2 + `FILTER` cycles. The resulting action registers one cycle later.
- `rx_strobe`/`rx_error` are high exactly `FILTER`+3 cycles after the first `clk_sys` edge that samples the 11th clock low.
- `tx_busy` rises the cycle after `tx_strobe`. `ps2_clk_out` falls in that same cycle.
- `ps2_clk_out` stays low for exactly `INHIBIT_CYCLES` cycles.
- The data bit for edge n changes `FILTER`+3 cycles after the pin falling edge, well within the device's clock-low half-period.
- `tx_done` and `rx_strobe` are never both high in the same cycle, because the two paths are mutually exclusive.

## Test plan
- **RX good:** device sends 0x1C, parity 0, stop 1 → one `rx_strobe`, `rx_data`=0x1C, no `rx_error`.
- **RX parity error:** 0x1C sent with parity 1 → one `rx_error`, no `rx_strobe`, `rx_data` unchanged.
- **RX timeout:** device stops after 4 bits → `rx_error` exactly `TIMEOUT_CYCLES` after the last edge (± sync latency); lines idle; the next 0x5A frame is received correctly.
- **TX with ACK:** `tx_strobe`, `tx_data`=0xED; device model clocks and ACKs →
  - clock low for `INHIBIT_CYCLES`;
  - device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `tx_done`=1 with `tx_error`=0.
- **TX NACK, and busy rejection:** `tx_strobe` 0xFF; device leaves data high at the ACK edge → `tx_done` with `tx_error`=1. A second `tx_strobe` while busy is ignored.
- **Glitch and reset:** a clock glitch of `FILTER`−1 cycles is ignored. `reset` mid-TX → both outputs 1 the next cycle, `tx_busy`=0, no `tx_done`.

Source files
------------

// File: rtl/ps2_host.sv
// ps2_host: host-side PS/2 controller in the clk_sys domain.
// Receives device-to-host frames and transmits host-to-device command bytes
// over an open-drain PS/2 clock/data pair. Outputs are release-high
// (1 = line released, 0 = drive low).
//
// Ports
//   i_clk_sys      system clock
//   i_reset        synchronous active-high reset
//   i_ps2_clk_in   PS/2 clock line level (asynchronous)
//   i_ps2_dat_in   PS/2 data line level (asynchronous)
//   o_ps2_clk_out  0 drives the clock line low, 1 releases it
//   o_ps2_dat_out  0 drives the data line low, 1 releases it
//   i_tx_data      command byte, sampled with i_tx_strobe
//   i_tx_strobe    one-cycle transmit request, ignored while busy
//   o_tx_busy      transmission in progress
//   o_tx_done      one-cycle pulse at end of transmission
//   o_tx_error     valid with o_tx_done: no ACK or timeout
//   o_rx_data      last good received byte
//   o_rx_strobe    one-cycle pulse when o_rx_data updates
//   o_rx_error     one-cycle pulse on bad start/parity/stop or timeout
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | lines released, waiting for a start edge or a tx request
// S_RX      | shifting in data, parity and stop on device clock falls
// S_TX_INH  | holding the clock low to inhibit the device
// S_TX_REQ  | start bit driven, clock released, waiting for first fall
// S_TX_BITS | driving data bits, parity and stop on device clock falls
// S_TX_ACK  | waiting for the ACK clock fall to sample the data line
// S_TX_WAIT | waiting for both lines to return high
module ps2_host #(
   parameter int FILTER         = 8,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       i_clk_sys,
   input  logic       i_reset,
   input  logic       i_ps2_clk_in,
   input  logic       i_ps2_dat_in,
   output logic       o_ps2_clk_out,
   output logic       o_ps2_dat_out,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_strobe,
   output logic       o_tx_busy,
   output logic       o_tx_done,
   output logic       o_tx_error,
   output logic [7:0] o_rx_data,
   output logic       o_rx_strobe,
   output logic       o_rx_error
);

   localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int FW   = $clog2(FILTER + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RX, S_TX_INH, S_TX_REQ, S_TX_BITS, S_TX_ACK, S_TX_WAIT
   } state_t;

   state_t         r_state;
   logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic           r_f_clk, r_f_dat, r_f_clk_prev;
   logic [FW-1:0]  r_clk_fcnt, r_dat_fcnt;
   logic [TW-1:0]  r_timer;
   logic [3:0]     r_bit_cnt;
   logic [7:0]     r_rx_shift;
   logic           r_rx_par;
   logic [7:0]     r_tx_byte;
   logic           r_tx_par;
   logic           r_nack;
   logic           r_clk_out, r_dat_out;
   logic           r_tx_busy, r_tx_done, r_tx_error;
   logic [7:0]     r_rx_data;
   logic           r_rx_strobe, r_rx_error;

   logic           w_fall;
   logic           w_tx_accept;
   logic           w_timer_zero;

   assign w_fall       = r_f_clk_prev & ~r_f_clk;
   assign w_tx_accept  = i_tx_strobe & ~r_tx_busy;
   assign w_timer_zero = (r_timer == '0);

   // Synchronizers and glitch filters: the filtered level only follows the
   // synced level after it has disagreed for FILTER consecutive cycles.
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_clk_s1     <= 1'b1;
         r_clk_s2     <= 1'b1;
         r_dat_s1     <= 1'b1;
         r_dat_s2     <= 1'b1;
         r_f_clk      <= 1'b1;
         r_f_dat      <= 1'b1;
         r_f_clk_prev <= 1'b1;
         r_clk_fcnt   <= '0;
         r_dat_fcnt   <= '0;
      end else begin
         r_clk_s1     <= i_ps2_clk_in;
         r_clk_s2     <= r_clk_s1;
         r_dat_s1     <= i_ps2_dat_in;
         r_dat_s2     <= r_dat_s1;
         r_f_clk_prev <= r_f_clk;

         if (r_clk_s2 != r_f_clk) begin
            if (r_clk_fcnt == FW'(FILTER - 1)) begin
               r_f_clk    <= r_clk_s2;
               r_clk_fcnt <= '0;
            end else begin
               r_clk_fcnt <= r_clk_fcnt + 1'b1;
            end
         end else begin
            r_clk_fcnt <= '0;
         end

         if (r_dat_s2 != r_f_dat) begin
            if (r_dat_fcnt == FW'(FILTER - 1)) begin
               r_f_dat    <= r_dat_s2;
               r_dat_fcnt <= '0;
            end else begin
               r_dat_fcnt <= r_dat_fcnt + 1'b1;
            end
         end else begin
            r_dat_fcnt <= '0;
         end
      end
   end

   // Protocol FSM. r_timer is shared: inhibit length in S_TX_INH, frame
   // timeout everywhere else it runs.
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_bit_cnt   <= '0;
         r_rx_shift  <= '0;
         r_rx_par    <= 1'b0;
         r_tx_byte   <= '0;
         r_tx_par    <= 1'b0;
         r_nack      <= 1'b0;
         r_clk_out   <= 1'b1;
         r_dat_out   <= 1'b1;
         r_tx_busy   <= 1'b0;
         r_tx_done   <= 1'b0;
         r_tx_error  <= 1'b0;
         r_rx_data   <= '0;
         r_rx_strobe <= 1'b0;
         r_rx_error  <= 1'b0;
      end else begin
         r_rx_strobe <= 1'b0;
         r_rx_error  <= 1'b0;
         r_tx_done   <= 1'b0;

         if (w_tx_accept) begin
            // Any receive in progress is dropped without a report.
            r_tx_byte <= i_tx_data;
            r_tx_par  <= ~^i_tx_data;
            r_tx_busy <= 1'b1;
            r_clk_out <= 1'b0;
            r_dat_out <= 1'b1;
            r_timer   <= TW'(INHIBIT_CYCLES - 1);
            r_state   <= S_TX_INH;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_fall) begin
                     if (!r_f_dat) begin
                        r_bit_cnt <= '0;
                        r_timer   <= TW'(TIMEOUT_CYCLES - 1);
                        r_state   <= S_RX;
                     end else begin
                        r_rx_error <= 1'b1;
                     end
                  end
               end

               S_RX: begin
                  if (w_fall) begin
                     r_timer   <= TW'(TIMEOUT_CYCLES - 1);
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt < 4'd8) begin
                        r_rx_shift[r_bit_cnt[2:0]] <= r_f_dat;
                     end else if (r_bit_cnt == 4'd8) begin
                        r_rx_par <= r_f_dat;
                     end else begin
                        if ((^{r_rx_shift, r_rx_par}) && r_f_dat) begin
                           r_rx_data   <= r_rx_shift;
                           r_rx_strobe <= 1'b1;
                        end else begin
                           r_rx_error <= 1'b1;
                        end
                        r_state <= S_IDLE;
                     end
                  end else if (w_timer_zero) begin
                     r_rx_error <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end

               S_TX_INH: begin
                  // Falls caused by our own clock drive are ignored here.
                  if (w_timer_zero) begin
                     r_clk_out <= 1'b1;
                     r_dat_out <= 1'b0;
                     r_state   <= S_TX_REQ;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end

               S_TX_REQ: begin
                  if (w_fall) begin
                     r_dat_out <= r_tx_byte[0];
                     r_bit_cnt <= 4'd1;
                     r_timer   <= TW'(TIMEOUT_CYCLES - 1);
                     r_state   <= S_TX_BITS;
                  end
               end

               S_TX_BITS: begin
                  if (w_fall) begin
                     r_timer   <= TW'(TIMEOUT_CYCLES - 1);
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt < 4'd8) begin
                        r_dat_out <= r_tx_byte[r_bit_cnt[2:0]];
                     end else if (r_bit_cnt == 4'd8) begin
                        r_dat_out <= r_tx_par;
                     end else begin
                        r_dat_out <= 1'b1;
                        r_state   <= S_TX_ACK;
                     end
                  end else if (w_timer_zero) begin
                     r_clk_out  <= 1'b1;
                     r_dat_out  <= 1'b1;
                     r_tx_done  <= 1'b1;
                     r_tx_error <= 1'b1;
                     r_tx_busy  <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end

               S_TX_ACK: begin
                  if (w_fall) begin
                     r_nack  <= r_f_dat;
                     r_timer <= TW'(TIMEOUT_CYCLES - 1);
                     r_state <= S_TX_WAIT;
                  end else if (w_timer_zero) begin
                     r_clk_out  <= 1'b1;
                     r_dat_out  <= 1'b1;
                     r_tx_done  <= 1'b1;
                     r_tx_error <= 1'b1;
                     r_tx_busy  <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end

               S_TX_WAIT: begin
                  if (r_f_clk && r_f_dat) begin
                     r_tx_done  <= 1'b1;
                     r_tx_error <= r_nack;
                     r_tx_busy  <= 1'b0;
                     r_state    <= S_IDLE;
                  end else if (w_fall) begin
                     r_timer <= TW'(TIMEOUT_CYCLES - 1);
                  end else if (w_timer_zero) begin
                     r_clk_out  <= 1'b1;
                     r_dat_out  <= 1'b1;
                     r_tx_done  <= 1'b1;
                     r_tx_error <= 1'b1;
                     r_tx_busy  <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end

               default: begin
                  r_clk_out <= 1'b1;
                  r_dat_out <= 1'b1;
                  r_state   <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_ps2_clk_out = r_clk_out;
   assign o_ps2_dat_out = r_dat_out;
   assign o_tx_busy     = r_tx_busy;
   assign o_tx_done     = r_tx_done;
   assign o_tx_error    = r_tx_error;
   assign o_rx_data     = r_rx_data;
   assign o_rx_strobe   = r_rx_strobe;
   assign o_rx_error    = r_rx_error;

endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host: directed bench for ps2_host with an open-drain line model and
// a behavioural PS/2 device that sends frames, clocks host commands and ACKs.
module tb_ps2_host;

   localparam int FILT = 8;
   localparam int INH  = 50;
   localparam int TMO  = 2000;
   localparam int HALF = 30;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       dev_clk, dev_dat;
   logic [7:0] tx_data;
   logic       tx_strobe;
   logic       ps2_clk_out, ps2_dat_out;
   logic       tx_busy, tx_done, tx_error;
   logic [7:0] rx_data;
   logic       rx_strobe, rx_error;

   wire line_clk = dev_clk & ps2_clk_out;
   wire line_dat = dev_dat & ps2_dat_out;

   always #5 clk_sys = ~clk_sys;

   ps2_host #(.FILTER(FILT), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk_sys     (clk_sys),
      .i_reset       (reset),
      .i_ps2_clk_in  (line_clk),
      .i_ps2_dat_in  (line_dat),
      .o_ps2_clk_out (ps2_clk_out),
      .o_ps2_dat_out (ps2_dat_out),
      .i_tx_data     (tx_data),
      .i_tx_strobe   (tx_strobe),
      .o_tx_busy     (tx_busy),
      .o_tx_done     (tx_done),
      .o_tx_error    (tx_error),
      .o_rx_data     (rx_data),
      .o_rx_strobe   (rx_strobe),
      .o_rx_error    (rx_error)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_rx = 0, n_rxe = 0, n_done = 0, n_both = 0;
   logic last_err = 1'b0;
   int last_fall = 0;

   always @(posedge clk_sys) cyc++;

   always @(negedge clk_sys) begin
      if (rx_strobe === 1'b1) n_rx++;
      if (rx_error === 1'b1) n_rxe++;
      if (tx_done === 1'b1) begin
         n_done++;
         last_err = tx_error;
      end
      if (tx_done === 1'b1 && rx_strobe === 1'b1) n_both++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   // Device-to-host frame: start, 8 data LSB first, parity, stop; only the
   // first nbits bits are clocked.
   task automatic dev_send(input logic [7:0] d, input logic par, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_dat = bits[i];
         wait_cyc(HALF);
         dev_clk   = 1'b0;
         last_fall = cyc;
         wait_cyc(HALF);
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
      wait_cyc(HALF);
   endtask

   // Host-to-device: clock 10 bits (sampled at rising edges), then the ACK
   // clock with data pulled low only when ack is set.
   task automatic dev_recv(output logic [9:0] got, input logic ack);
      got = '0;
      wait_cyc(HALF);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         wait_cyc(HALF);
         dev_clk = 1'b1;
         got[i]  = line_dat;
         wait_cyc(HALF);
      end
      dev_dat = ~ack;
      wait_cyc(HALF);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      wait_cyc(HALF);
      dev_dat = 1'b1;
      wait_cyc(40);
   endtask

   task automatic tx_start(input logic [7:0] d);
      tx_data   = d;
      tx_strobe = 1'b1;
      @(negedge clk_sys);
      tx_strobe = 1'b0;
   endtask

   // Counts negedges with the host clock drive low; optionally fires a
   // second request halfway through the inhibit.
   task automatic measure_inh(output int n, input logic second);
      n = 0;
      while (ps2_clk_out === 1'b0 && n < 4 * INH) begin
         tx_strobe = second && (n == INH / 2);
         if (tx_strobe) tx_data = 8'h12;
         n++;
         @(negedge clk_sys);
      end
      tx_strobe = 1'b0;
   endtask

   initial begin
      int n, base, delta;
      logic [9:0] got;

      reset     = 1'b1;
      dev_clk   = 1'b1;
      dev_dat   = 1'b1;
      tx_data   = 8'h00;
      tx_strobe = 1'b0;
      wait_cyc(4);
      check("reset_clk_out", {31'd0, ps2_clk_out}, 32'd1);
      check("reset_dat_out", {31'd0, ps2_dat_out}, 32'd1);
      check("reset_rx_data", {24'd0, rx_data}, 32'h00);
      check("reset_busy", {31'd0, tx_busy}, 32'd0);
      check("reset_pulses", {28'd0, rx_strobe, rx_error, tx_done, tx_error}, 32'd0);
      reset = 1'b0;
      wait_cyc(20);

      // RX good 0x1C, parity 0
      dev_send(8'h1C, 1'b0, 11);
      wait_cyc(20);
      check("rx_good_strobes", n_rx, 1);
      check("rx_good_errors", n_rxe, 0);
      check("rx_good_data", {24'd0, rx_data}, 32'h1C);

      // RX parity error
      dev_send(8'h1C, 1'b1, 11);
      wait_cyc(20);
      check("rx_par_errors", n_rxe, 1);
      check("rx_par_strobes", n_rx, 1);
      check("rx_par_data_held", {24'd0, rx_data}, 32'h1C);

      // RX timeout after start + 4 data bits
      base = n_rxe;
      dev_send(8'h0F, 1'b0, 5);
      n = 0;
      while (n_rxe == base && n < TMO + 300) begin
         @(negedge clk_sys);
         n++;
      end
      delta = cyc - last_fall;
      check("rx_timeout_seen", n_rxe, base + 1);
      check("rx_timeout_window", {31'd0, (delta >= TMO) && (delta <= TMO + FILT + 4)}, 32'd1);
      check("rx_timeout_lines", {30'd0, ps2_clk_out, ps2_dat_out}, 32'd3);
      wait_cyc(20);
      dev_send(8'h5A, 1'b1, 11);
      wait_cyc(20);
      check("rx_after_to_strobes", n_rx, 2);
      check("rx_after_to_data", {24'd0, rx_data}, 32'h5A);

      // TX 0xED with ACK
      tx_start(8'hED);
      check("tx_busy_rise", {31'd0, tx_busy}, 32'd1);
      check("tx_clk_fall", {31'd0, ps2_clk_out}, 32'd0);
      measure_inh(n, 1'b0);
      check("tx_inhibit_len", n, INH);
      check("tx_start_bit", {31'd0, ps2_dat_out}, 32'd0);
      dev_recv(got, 1'b1);
      check("tx_ack_bits", {22'd0, got}, {22'd0, 2'b11, 8'hED});
      check("tx_ack_done", n_done, 1);
      check("tx_ack_error", {31'd0, last_err}, 32'd0);
      check("tx_ack_busy", {31'd0, tx_busy}, 32'd0);
      check("tx_ack_no_rx", n_rx + n_rxe, 2 + base + 1);

      // TX 0xFF with NACK, second request while busy ignored
      tx_start(8'hFF);
      measure_inh(n, 1'b1);
      check("tx_nack_inhibit_len", n, INH);
      dev_recv(got, 1'b0);
      check("tx_nack_bits", {22'd0, got}, {22'd0, 2'b11, 8'hFF});
      check("tx_nack_done", n_done, 2);
      check("tx_nack_error", {31'd0, last_err}, 32'd1);
      wait_cyc(INH + 20);
      check("tx_busy_reject", {30'd0, tx_busy, ps2_clk_out}, 32'd1);

      // Glitches on the clock line: FILTER-1 ignored, FILTER accepted
      base = n_rxe;
      dev_clk = 1'b0;
      wait_cyc(FILT - 1);
      dev_clk = 1'b1;
      wait_cyc(40);
      check("glitch_short_ignored", n_rxe, base);
      dev_clk = 1'b0;
      wait_cyc(FILT);
      dev_clk = 1'b1;
      wait_cyc(40);
      check("glitch_full_accepted", n_rxe, base + 1);

      // Reset while the start bit is driven
      base = n_done;
      tx_start(8'h55);
      measure_inh(n, 1'b0);
      check("rst_pre_start_bit", {31'd0, ps2_dat_out}, 32'd0);
      reset = 1'b1;
      @(negedge clk_sys);
      check("rst_lines_released", {30'd0, ps2_clk_out, ps2_dat_out}, 32'd3);
      check("rst_busy_clear", {31'd0, tx_busy}, 32'd0);
      reset = 1'b0;
      wait_cyc(100);
      check("rst_no_done", n_done, base);
      check("never_both_pulses", n_both, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
